aes_round_ctrl: RTL

//  Sequencer for the iterative AES encryption round datapath
//  (SubBytes/ShiftRows/MixColumns/AddRoundKey, one round per round_en).

---
 rtl/aes_round_ctrl_if.sv | 22 ++
 rtl/aes_round_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl_if.sv
// Block handshake bundle between the AES round sequencer and its
// upstream producer / downstream consumer.
interface aes_round_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES encryption datapath:
// block handshake, round stepping, rcon and final-round bypass.
module aes_round_ctrl #(
  parameter int NR           = 10,
  parameter int ROUND_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_round_ctrl_if.slave    hs,
  output logic               load,
  output logic               round_en,
  output logic [3:0]         round_o,
  output logic               mix_bypass,
  output logic [7:0]         rcon_o,
  input  logic               abort,
  output logic               busy
);

  localparam int CW = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_ctrl: NR must be 10, 12 or 14");
  end
  if (ROUND_CYCLES < 1) begin : g_bad_rc
    $error("aes_round_ctrl: ROUND_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      rnd_q, rnd_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [7:0]      rcon_q, rcon_d;

  logic is_idle, is_run, is_done;
  logic last_cyc, last_rnd, fire, accept;
  logic [7:0] rcon_nx;

  assign is_idle  = (state_q == IDLE);
  assign is_run   = (state_q == RUN);
  assign is_done  = (state_q == DONE);
  assign last_cyc = (cyc_q == CW'(ROUND_CYCLES - 1));
  assign last_rnd = (rnd_q == 4'(NR));
  assign fire     = is_run & last_cyc;
  assign accept   = is_idle & hs.in_valid & ~abort & rst_n;
  // xtime in GF(2^8): multiply by x modulo the AES polynomial
  assign rcon_nx  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      cyc_q   <= '0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      cyc_q   <= cyc_d;
      rcon_q  <= rcon_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    cyc_d   = cyc_q;
    rcon_d  = rcon_q;
    if (abort) begin
      state_d = IDLE;
      rnd_d   = 4'd0;
      cyc_d   = '0;
      rcon_d  = 8'h01;
    end else begin
      unique case (1'b1)
        is_idle: begin
          if (hs.in_valid) begin
            state_d = RUN;
            rnd_d   = 4'd1;
            cyc_d   = '0;
            rcon_d  = 8'h01;
          end
        end
        is_run: begin
          if (fire) begin
            cyc_d = '0;
            // counter parks at 0 after the last round so it never wraps
            if (last_rnd) begin
              state_d = DONE;
              rnd_d   = 4'd0;
              rcon_d  = 8'h01;
            end else begin
              rnd_d  = rnd_q + 4'd1;
              rcon_d = rcon_nx;
            end
          end else begin
            cyc_d = cyc_q + CW'(1);
          end
        end
        is_done: begin
          if (hs.out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          rnd_d   = 4'd0;
          cyc_d   = '0;
          rcon_d  = 8'h01;
        end
      endcase
    end
  end

  always_comb begin
    hs.in_ready  = is_idle;
    hs.out_valid = is_done;
    load         = accept;
    round_en     = fire;
    round_o      = fire ? rnd_q : 4'd0;
    mix_bypass   = fire & last_rnd;
    rcon_o       = rcon_q;
    busy         = ~is_idle;
  end

endmodule
